// File: rtl/tag_frame_ctrl_if.sv
// Frame hand-off bus between tag_frame_ctrl and the host logic.
//   frame       : captured payload, first-received bit in the MSB
//   frame_valid : frame is held and stable
//   frame_ack   : single-cycle strobe from the consumer
// master = frame producer (tag_frame_ctrl), slave = host consumer.
interface tag_frame_ctrl_if #(
  parameter int unsigned FRAME_BITS = 44
);
  logic [FRAME_BITS-1:0] frame;
  logic                  frame_valid;
  logic                  frame_ack;

  modport master (output frame, output frame_valid, input frame_ack);
  modport slave  (input frame, input frame_valid, output frame_ack);
endinterface

// File: rtl/tag_frame_ctrl.sv
// Frame-level controller behind the FSK frequency decoder of the 125 kHz reader.
// Recovers a bit clock from the carrier pulses, slices the demodulated data,
// hunts for the tag preamble, captures a fixed-length frame and hands it to
// the host over a valid/ack handshake. Also drives the decoder clear.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   enable_i          : level, 1 = run
//   sq_wv_i           : raw carrier square wave (async)
//   data_in_i         : demodulated bit from the decoder (async)
//   dec_clear_o       : decoder manual clear
//   busy_o            : high while capturing a frame
//   carrier_ok_o      : carrier pulse seen within the last LOSS_CYCLES
//   carrier_lost_o    : one-cycle pulse on carrier loss
//   fbus              : frame / frame_valid / frame_ack hand-off
module tag_frame_ctrl #(
  parameter int unsigned        BIT_TICKS   = 50,
  parameter int unsigned        PRE_LEN     = 8,
  parameter logic [PRE_LEN-1:0] PREAMBLE    = PRE_LEN'(8'h1D),
  parameter int unsigned        FRAME_BITS  = 44,
  parameter int unsigned        LOSS_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             sq_wv_i,
  input  logic             data_in_i,
  output logic             dec_clear_o,
  output logic             busy_o,
  output logic             carrier_ok_o,
  output logic             carrier_lost_o,
  tag_frame_ctrl_if.master fbus
);

  localparam int unsigned TC_W = $clog2(BIT_TICKS);
  localparam int unsigned BC_W = $clog2(FRAME_BITS + 1);
  localparam int unsigned LC_W = $clog2(LOSS_CYCLES + 1);

  localparam logic [TC_W-1:0] TC_MAX  = TC_W'(BIT_TICKS - 1);
  localparam logic [TC_W-1:0] TC_HALF = TC_W'(BIT_TICKS / 2);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS - 1);
  localparam logic [LC_W-1:0] LC_SAT  = LC_W'(LOSS_CYCLES);
  localparam logic [LC_W-1:0] LC_EDGE = LC_W'(LOSS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Synchronisers plus one edge register each; tick/dedge are registered compares.
  logic [1:0] sq_sync_q, dat_sync_q;
  logic       sq_prev_q, dat_prev_q;
  logic       tick_q, dedge_q;

  logic [TC_W-1:0] tick_cnt_q;
  logic [LC_W-1:0] loss_cnt_q;
  logic            carrier_ok_q, carrier_lost_q;

  logic [PRE_LEN-1:0]    pat_q, pat_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  dec_clear_q, dec_clear_d;
  logic                  busy_q, busy_d;

  logic                  sample_c, loss_evt_c, last_bit_c, pre_match_c;
  logic [PRE_LEN-1:0]    pat_shift_c;
  logic [FRAME_BITS-1:0] frame_shift_c;

  // dat_prev_q is the synchronised data aligned with dedge_q.
  assign sample_c      = tick_q && (tick_cnt_q == TC_HALF);
  assign loss_evt_c    = !tick_q && (loss_cnt_q == LC_EDGE);
  assign last_bit_c    = (bit_cnt_q == BC_LAST);
  assign pat_shift_c   = PRE_LEN'({pat_q, dat_prev_q});
  assign frame_shift_c = FRAME_BITS'({frame_q, dat_prev_q});
  assign pre_match_c   = (pat_shift_c == PREAMBLE);

  // Input synchronisers and edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_sync_q  <= '0;
      dat_sync_q <= '0;
      sq_prev_q  <= 1'b0;
      dat_prev_q <= 1'b0;
      tick_q     <= 1'b0;
      dedge_q    <= 1'b0;
    end else begin
      sq_sync_q  <= {sq_sync_q[0], sq_wv_i};
      dat_sync_q <= {dat_sync_q[0], data_in_i};
      sq_prev_q  <= sq_sync_q[1];
      dat_prev_q <= dat_sync_q[1];
      tick_q     <= sq_sync_q[1] & ~sq_prev_q;
      dedge_q    <= dat_sync_q[1] ^ dat_prev_q;
    end
  end

  // Bit timer: a data edge re-centres the cell and beats a same-cycle tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (dedge_q) begin
      tick_cnt_q <= '0;
    end else if (tick_q) begin
      tick_cnt_q <= (tick_cnt_q == TC_MAX) ? '0 : tick_cnt_q + TC_W'(1);
    end
  end

  // Carrier loss timer; saturation stops repeated loss pulses until a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q     <= '0;
      carrier_ok_q   <= 1'b0;
      carrier_lost_q <= 1'b0;
    end else begin
      carrier_lost_q <= loss_evt_c;
      if (tick_q) begin
        loss_cnt_q   <= '0;
        carrier_ok_q <= 1'b1;
      end else begin
        if (loss_cnt_q != LC_SAT) loss_cnt_q <= loss_cnt_q + LC_W'(1);
        if (loss_evt_c) carrier_ok_q <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: enable drop > carrier loss > sample/ack.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_HUNT;
        ST_HUNT:    if (!loss_evt_c && sample_c && pre_match_c) state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          if (loss_evt_c)                  state_d = ST_HUNT;
          else if (sample_c && last_bit_c) state_d = ST_HOLD;
        end
        ST_HOLD:    if (fbus.frame_ack) state_d = ST_HUNT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    pat_d         = pat_q;
    frame_d       = frame_q;
    bit_cnt_d     = bit_cnt_q;
    frame_valid_d = frame_valid_q;
    dec_clear_d   = 1'b0;
    busy_d        = (state_d == ST_CAPTURE);
    if (!enable_i) begin
      pat_d         = '0;
      bit_cnt_d     = '0;
      frame_valid_d = 1'b0;
      dec_clear_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pat_d         = '0;
          frame_valid_d = 1'b0;
          dec_clear_d   = 1'b1;  // held for the first HUNT cycle as well
        end
        ST_HUNT: begin
          if (loss_evt_c) begin
            pat_d       = '0;
            dec_clear_d = 1'b1;
          end else if (sample_c) begin
            pat_d = pat_shift_c;
            if (pre_match_c) begin
              bit_cnt_d = '0;
              frame_d   = '0;
            end
          end
        end
        ST_CAPTURE: begin
          if (loss_evt_c) begin
            pat_d       = '0;
            frame_d     = '0;
            bit_cnt_d   = '0;
            dec_clear_d = 1'b1;
          end else if (sample_c) begin
            frame_d   = frame_shift_c;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (last_bit_c) frame_valid_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (fbus.frame_ack) begin
            frame_valid_d = 1'b0;
            pat_d         = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q         <= '0;
      frame_q       <= '0;
      bit_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      dec_clear_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      pat_q         <= pat_d;
      frame_q       <= frame_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_valid_q <= frame_valid_d;
      dec_clear_q   <= dec_clear_d;
      busy_q        <= busy_d;
    end
  end

  assign dec_clear_o      = dec_clear_q;
  assign busy_o           = busy_q;
  assign carrier_ok_o     = carrier_ok_q;
  assign carrier_lost_o   = carrier_lost_q;
  assign fbus.frame       = frame_q;
  assign fbus.frame_valid = frame_valid_q;

endmodule
